s_axis_rq_skid_x4: RTL

- Upstream neighbour of the x4 RQ adapter: sits between the litepcie requester TX stream and the adapter's `s_axis_rq_*_a` inputs.
- Adds a 2-entry skid buffer so the sink-side tready is a pure register, breaking the combinational path from the PCIe hard block's tready.
- Latches per-packet first byte-enables into tuser for every beat.
- Tracks packet framing and flags over-long packets.

---
 rtl/s_axis_rq_skid_x4.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/s_axis_rq_skid_x4.sv
// RQ stream skid buffer with first_be tagging and overlong-packet flag; RQ_SKID_STATS_EN adds pkt/stall counters.
// Latency: 1 cycle from sink accept to s_axis_rq_tvalid_a when the buffer is empty.
// Backpressure: sink_tready is a register (= skid entry free); 1 beat/cycle sustained with tready_a[0] high.
module s_axis_rq_skid_x4 #(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_BEATS  = 256
) (
    input  logic                  user_clk,
    input  logic                  user_reset,
    input  logic [DATA_WIDTH-1:0] sink_tdata,
    input  logic [KEEP_WIDTH-1:0] sink_tkeep,
    input  logic                  sink_tlast,
    input  logic                  sink_tvalid,
    output logic                  sink_tready,
    input  logic [3:0]            sink_first_be,
    output logic [DATA_WIDTH-1:0] s_axis_rq_tdata_a,
    output logic [KEEP_WIDTH-1:0] s_axis_rq_tkeep_a,
    output logic                  s_axis_rq_tlast_a,
    output logic [3:0]            s_axis_rq_tuser_a,
    output logic                  s_axis_rq_tvalid_a,
    input  logic [3:0]            s_axis_rq_tready_a,
    output logic                  err_overlong
`ifdef RQ_SKID_STATS_EN
    ,
    output logic [31:0]           pkt_count,
    output logic [31:0]           stall_count
`endif
);

    localparam int CW = $clog2(MAX_BEATS) + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [3:0]            user;
    } beat_t;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t         state_q, state_d;
    beat_t          main_q, skid_q, in_beat;
    logic           main_vld, skid_vld, skid_vld_d;
    logic [3:0]     first_be_q;
    logic [CW-1:0]  beat_cnt;
    logic           accept, drain;
    logic           unused_rdy;

    assign unused_rdy = ^s_axis_rq_tready_a[3:1];
    assign accept     = sink_tvalid & sink_tready;
    assign drain      = main_vld & s_axis_rq_tready_a[0];

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                IDLE:    if (!sink_tlast) state_d = IN_PKT;
                IN_PKT:  if (sink_tlast)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_beat.data = sink_tdata;
        in_beat.keep = sink_tkeep;
        in_beat.last = sink_tlast;
        in_beat.user = (state_q == IDLE) ? sink_first_be : first_be_q;
    end

    // A full skid entry blocks the input, so a drain and a skid load never coincide.
    always_comb begin
        skid_vld_d = skid_vld;
        if (drain)
            skid_vld_d = 1'b0;
        else if (accept && main_vld)
            skid_vld_d = 1'b1;
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state_q      <= IDLE;
            main_q       <= '0;
            skid_q       <= '0;
            main_vld     <= 1'b0;
            skid_vld     <= 1'b0;
            sink_tready  <= 1'b0;
            first_be_q   <= 4'h0;
            beat_cnt     <= '0;
            err_overlong <= 1'b0;
        end else begin
            state_q     <= state_d;
            skid_vld    <= skid_vld_d;
            sink_tready <= !skid_vld_d;
            if (accept && state_q == IDLE)
                first_be_q <= sink_first_be;

            if (drain) begin
                if (skid_vld)
                    main_q <= skid_q;
                else if (accept)
                    main_q <= in_beat;
                else
                    main_vld <= 1'b0;
            end else if (accept) begin
                if (!main_vld) begin
                    main_q   <= in_beat;
                    main_vld <= 1'b1;
                end else begin
                    skid_q <= in_beat;
                end
            end

            // Count is of beats already sent in this packet, so MAX_BEATS-1 means this one hits the limit.
            if (drain) begin
                if (main_q.last) begin
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (beat_cnt == CW'(MAX_BEATS - 1))
                        err_overlong <= 1'b1;
                end
            end
        end
    end

    assign s_axis_rq_tdata_a  = main_q.data;
    assign s_axis_rq_tkeep_a  = main_q.keep;
    assign s_axis_rq_tlast_a  = main_q.last;
    assign s_axis_rq_tuser_a  = main_q.user;
    assign s_axis_rq_tvalid_a = main_vld;

`ifdef RQ_SKID_STATS_EN
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            pkt_count   <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (drain && main_q.last && pkt_count != 32'hFFFF_FFFF)
                pkt_count <= pkt_count + 32'h1;
            if (main_vld && !s_axis_rq_tready_a[0] && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'h1;
        end
    end
`endif

endmodule
